buffer_ifid_skid: RTL and testbench
===================================

// Module: buffer_ifid_skid
// PURPOSE
//  Parametrised IF->ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
//  Sustains 1 instr/cycle with registered in_ready; supports flush (branch/jump redirect) and stall counting.
//  Sits between fetch (instruction memory + PC) and decode.
//  Successor to the plain enable-gated IF/ID register.
// PARAMETERS
//  INSTR_W  32            instruction width
//  PC_W     64            PC width
//  NOP      32'h00000013  instruction presented when no valid entry (addi x0,x0,0)
//  CNT_W    16            stall counter width
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        async active-low reset
//  in_valid   in   1        fetch presents in_instr/in_pc
//  in_ready   out  1        stage accepts this cycle (registered)
//  in_instr   in   INSTR_W  fetched instruction
//  in_pc      in   PC_W     PC of in_instr
//  out_valid  out  1        out_instr/out_pc are valid
//  out_ready  in   1        decode consumes this cycle
//  out_instr  out  INSTR_W  instruction to decode
//  out_pc     out  PC_W     PC to decode
//  flush      in   1        discard all held entries
//  stall_cnt  out  CNT_W    cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//    out_valid=0, out_instr=NOP, out_pc=0, stall_cnt=0, skid empty.
//    in_ready=0 while rst_n=0; 1 from the first edge after release.
//  Storage: main reg (drives outputs) + skid reg. States EMPTY / ONE (main) / TWO (main+skid).
//  acc = in_valid & in_ready; dq = out_valid & out_ready. All updates on posedge clk.
//    EMPTY: acc -> ONE, main<=in.
//    ONE:
//      acc&dq -> ONE, main<=in.
//      acc&!dq -> TWO, skid<=in.
//      !acc&dq -> EMPTY.
//      else hold.
//    TWO:
//      dq -> ONE, main<=skid.
//      acc is impossible because in_ready=0.
//  in_ready = (state!=TWO), registered; a held-high in_valid is never lost.
//  Latency: 1 cycle in->out when empty and out_ready=1; throughput 1/cycle.
//  Ordering: strict FIFO; skid never bypasses main.
//  out_instr = NOP and out_pc = 0 whenever out_valid=0; no stale data at outputs.
//  flush (highest priority):
//    Next state EMPTY, out_valid=0, out_instr=NOP.
//    Same-cycle input and dequeue are dropped/ignored.
//    in_ready=1 next cycle.
//  stall_cnt: +1 per cycle with out_valid & !out_ready & !flush; saturates at 2^CNT_W-1 (no wrap).
//  Reset mid-operation: immediate return to reset values; held entries discarded.
//  in_pc/in_instr are sampled only on acc; don't-care otherwise.
// STRUCTURE
//  Package pipe_pkg:
//    NOP_INSTR constant.
//    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t.
//    typedef struct packed {instr; pc} ifid_t.
//  One sub-module: pipe_entry_reg (valid + ifid_t payload, load/clear, async reset).
//    Instantiated twice (main, skid).
//  FSM and stall counter live in the top.
// TESTING
//  1. Reset, stream 0x00A00093 @PC 0x0, 0x00B00113 @0x4, out_ready=1
//     -> out_valid 1 cycle after each, in order, in_ready stays 1.
//  2. Stream 3 instr, out_ready=0 from 2nd
//     -> state TWO, in_ready=0 after 2 accepts; release -> PCs 0x0,0x4,0x8 in order, none lost.
//  3. TWO state + flush=1 with in_valid=1
//     -> next cycle out_valid=0, out_instr=0x00000013, in_ready=1; flushed input never appears.
//  4. out_valid=1, out_ready=0 for 5 cycles
//     -> stall_cnt=5; with CNT_W=2 and 5 stall cycles -> stall_cnt=3 (saturated).
//  5. rst_n low mid-stream (async, between edges)
//     -> outputs reset immediately; in_ready=0 until release.
//  6. Random valid/ready, 10k cycles, scoreboard
//     -> out sequence == accepted sequence; in_ready never 1 in TWO.

Source files
------------

// File: rtl/buffer_ifid_skid_pkg.sv
// Shared types and constants for the IF->ID skid-buffered pipeline register.
package pipe_pkg;

    localparam int unsigned IFID_INSTR_W = 32;
    localparam int unsigned IFID_PC_W    = 64;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [IFID_INSTR_W-1:0] instr;
        logic [IFID_PC_W-1:0]    pc;
    } ifid_t;

endpackage

// File: rtl/buffer_ifid_skid_entry_reg.sv
// One storage slot: valid flag plus payload, with load/clear and async reset.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter type T = ifid_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  T     d,
    output logic valid,
    output T     q
);

    // Clear wins over load so a flushed slot never captures same-cycle data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/buffer_ifid_skid.sv
// IF->ID pipeline register with valid/ready handshake, 2-entry skid, flush and stall counter.
module buffer_ifid_skid
    import pipe_pkg::*;
#(
    parameter int unsigned         INSTR_W = 32,
    parameter int unsigned         PC_W    = 64,
    parameter logic [INSTR_W-1:0]  NOP     = INSTR_W'(NOP_INSTR),
    parameter int unsigned         CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               flush,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    skid_state_t state_q, state_d;
    logic        in_ready_q;
    logic        acc, dq;
    logic        main_load, main_clr, main_from_skid, skid_load, skid_clr;
    logic        main_valid, skid_valid;
    entry_t      in_entry, main_d, main_q, skid_q;
    logic [CNT_W-1:0] stall_q;

    assign in_entry = '{instr: in_instr, pc: in_pc};
    assign acc      = in_valid & in_ready_q;
    assign dq       = main_valid & out_ready;
    assign main_d   = main_from_skid ? skid_q : in_entry;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    state_d   = ONE;
                    main_load = 1'b1;
                end
                ONE: begin
                    if (acc && dq) begin
                        main_load = 1'b1;
                    end else if (acc) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end else if (dq) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
                    end
                end
                TWO: if (dq) begin
                    state_d        = ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state so it is low exactly while TWO is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!flush && main_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    pipe_entry_reg #(.T(entry_t)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_entry_reg #(.T(entry_t)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_entry),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_instr = main_valid ? main_q.instr : NOP;
    assign out_pc    = main_valid ? main_q.pc : '0;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_buffer_ifid_skid.sv
// Directed and randomised scoreboard checks for buffer_ifid_skid.
module tb_buffer_ifid_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] out_instr, out_instr2;
    logic [63:0] out_pc, out_pc2;
    logic        flush;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int asserts  = 0;
    int failures = 0;

    always #5 clk = ~clk;

    buffer_ifid_skid dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .flush(flush), .stall_cnt(stall_cnt)
    );

    buffer_ifid_skid #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_pc(out_pc2), .flush(flush), .stall_cnt(stall_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_out(input string name, input logic v, input logic [31:0] ins,
                           input logic [63:0] pc, input logic rdy);
        asserts++;
        if (out_valid !== v || out_instr !== ins || out_pc !== pc || in_ready !== rdy) begin
            failures++;
            $display("FAIL %s: got v=%b instr=%h pc=%h rdy=%b, want v=%b instr=%h pc=%h rdy=%b",
                     name, out_valid, out_instr, out_pc, in_ready, v, ins, pc, rdy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_instr = '0; in_pc = '0;
        tick();
        chk_out("reset_outputs", 1'b0, 32'h13, 64'h0, 1'b0);
        asserts++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_stall: got %0d want 0", stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_out("reset_release", 1'b0, 32'h13, 64'h0, 1'b1);
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid  = 1'b1; in_instr = 32'h00A00093; in_pc = 64'h0;
        tick();
        chk_out("stream_first", 1'b1, 32'h00A00093, 64'h0, 1'b1);
        in_instr = 32'h00B00113; in_pc = 64'h4;
        tick();
        chk_out("stream_second", 1'b1, 32'h00B00113, 64'h4, 1'b1);
        in_valid = 1'b0;
        tick();
        chk_out("stream_drain", 1'b0, 32'h13, 64'h0, 1'b1);
    endtask

    task automatic test_skid();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'h00100093; in_pc = 64'h0;
        tick();
        chk_out("skid_one", 1'b1, 32'h00100093, 64'h0, 1'b1);
        in_instr = 32'h00200113; in_pc = 64'h4;
        tick();
        chk_out("skid_two", 1'b1, 32'h00100093, 64'h0, 1'b0);
        in_instr = 32'h00300193; in_pc = 64'h8;
        tick();
        chk_out("skid_hold", 1'b1, 32'h00100093, 64'h0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_out("skid_pop4", 1'b1, 32'h00200113, 64'h4, 1'b1);
        tick();
        chk_out("skid_pop8", 1'b1, 32'h00300193, 64'h8, 1'b1);
        in_valid = 1'b0;
        tick();
        chk_out("skid_empty", 1'b0, 32'h13, 64'h0, 1'b1);
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'h00100093; in_pc = 64'h0;
        tick();
        in_instr = 32'h00200113; in_pc = 64'h4;
        tick();
        chk_out("flush_pre_two", 1'b1, 32'h00100093, 64'h0, 1'b0);
        flush = 1'b1; in_instr = 32'hDEADBEEF; in_pc = 64'h100;
        tick();
        chk_out("flush_two", 1'b0, 32'h13, 64'h0, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk_out("flush_no_ghost", 1'b0, 32'h13, 64'h0, 1'b1);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 64'h200;
        tick();
        chk_out("flush_pre_one", 1'b1, 32'h00400213, 64'h200, 1'b1);
        flush = 1'b1; in_instr = 32'hCAFEF00D; in_pc = 64'h204;
        tick();
        chk_out("flush_one", 1'b0, 32'h13, 64'h0, 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk_out("flush_one_after", 1'b0, 32'h13, 64'h0, 1'b1);
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'h00500293; in_pc = 64'h40;
        tick();
        in_valid = 1'b0;
        asserts++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL stall_start: got %0d want 0", stall_cnt);
        end
        for (int i = 0; i < 5; i++) tick();
        asserts++;
        if (stall_cnt !== 16'd5) begin
            failures++;
            $display("FAIL stall_five: got %0d want 5", stall_cnt);
        end
        asserts++;
        if (stall_cnt2 !== 2'd3) begin
            failures++;
            $display("FAIL stall_saturate: got %0d want 3", stall_cnt2);
        end
        out_ready = 1'b1;
        tick();
        asserts++;
        if (stall_cnt !== 16'd5 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: got cnt=%0d v=%b want cnt=5 v=0", stall_cnt, out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1; in_instr = 32'h00600313; in_pc = 64'h300;
        tick();
        chk_out("areset_pre", 1'b1, 32'h00600313, 64'h300, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("areset_immediate", 1'b0, 32'h13, 64'h0, 1'b0);
        tick();
        chk_out("areset_held", 1'b0, 32'h13, 64'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_out("areset_release", 1'b0, 32'h13, 64'h0, 1'b1);
        tick();
        chk_out("areset_accept", 1'b1, 32'h00600313, 64'h300, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [95:0] q[$];
        logic [15:0] exp_stall;
        logic        iv, orr, acc, dq;
        int          rfail;
        do_reset();
        exp_stall = '0;
        rfail     = 0;
        for (int c = 0; c < 10000; c++) begin
            asserts++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) ||
                stall_cnt !== exp_stall ||
                (q.size() != 0 && {out_instr, out_pc} !== q[0])) begin
                failures++;
                rfail++;
                if (rfail <= 10)
                    $display("FAIL random_cycle%0d: got v=%b rdy=%b data=%h cnt=%0d, want v=%b rdy=%b data=%h cnt=%0d",
                             c, out_valid, in_ready, {out_instr, out_pc}, stall_cnt,
                             (q.size() != 0), (q.size() < 2),
                             (q.size() != 0) ? q[0] : {32'h13, 64'h0}, exp_stall);
            end
            iv  = ($urandom_range(0, 99) < 60);
            orr = ($urandom_range(0, 99) < 55);
            in_valid  = iv;
            out_ready = orr;
            in_instr  = $urandom;
            in_pc     = {$urandom, $urandom};
            acc = iv && (q.size() < 2);
            dq  = orr && (q.size() != 0);
            if (q.size() != 0 && !orr && exp_stall != 16'hFFFF) exp_stall++;
            tick();
            if (dq) void'(q.pop_front());
            if (acc) q.push_back({in_instr, in_pc});
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_stall();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
